// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive path and its companion blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StAckSetup,
    StAckHold,
    StWaitStop
  } rx_state_e;

  localparam logic SdaRelease = 1'b0;
  localparam logic SdaDrive   = 1'b1;

endpackage

// File: rtl/i2c_rx_fifo.sv
// Synchronous FIFO with valid/ready read side; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module i2c_rx_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             space_o,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             full, empty, pop, push;

  assign empty   = (wptr_q == rptr_q);
  // Extra pointer bit separates full (wrapped once) from empty.
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop     = !empty && ready_i;
  assign space_o = !full || pop;
  assign push    = push_i && space_o;
  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PtrOne;
    if (pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/i2c_rx_burst.sv
// I2C receive path: START/STOP detection, word shifting with ACK/NACK on the 9th
// clock, and a FIFO-buffered output stream for multi-word bursts.
module i2c_rx_burst
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  input  logic              rx_en_i,
  input  logic [7:0]        burst_len_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_last_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  rx_state_e           state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]          word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                ack_q, ack_d;
  logic                sda_oe_q, sda_oe_d;
  logic                start_q, start_d, stop_q, stop_d;
  logic                overflow_q, overflow_d;
  logic                rx_en_q;
  logic                en_rise, space, push, push_last, burst_ok;
  logic [DATA_W:0]     fifo_rdata;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s && !scl_hist_q;
  assign scl_fall   = !scl_s && scl_hist_q;
  assign start_det  = sda_hist_q && !sda_s && scl_s;
  assign stop_det   = !sda_hist_q && sda_s && scl_s;
  assign en_rise    = rx_en_i && !rx_en_q;
  assign burst_ok   = (burst_len_i == 8'd0) ||
                      (({1'b0, word_cnt_q} + 9'd1) < {1'b0, burst_len_i});

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_last  = 1'b0;
    if (en_rise) overflow_d = 1'b0;

    if (!rx_en_i) begin
      state_d  = StIdle;
      sda_oe_d = SdaRelease;
    end else if (state_q == StIdle) begin
      if (start_det) begin
        start_d    = 1'b1;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = StShift;
      end
    end else if (stop_det) begin
      stop_d   = 1'b1;
      sda_oe_d = SdaRelease;
      state_d  = StIdle;
    end else if (start_det) begin
      // Repeated START: any partial word is simply abandoned.
      start_d    = 1'b1;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      sda_oe_d   = SdaRelease;
      state_d    = StShift;
    end else begin
      case (state_q)
        StShift: begin
          if (scl_rise) begin
            if (MSB_FIRST != 0) shreg_d = {shreg_q[DATA_W-2:0], sda_s};
            else                shreg_d = {sda_s, shreg_q[DATA_W-1:1]};
            if (bit_cnt_q == BitLast) begin
              bit_cnt_d = '0;
              ack_d     = space && burst_ok;
              state_d   = StAckSetup;
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
          end
        end
        StAckSetup: begin
          if (scl_fall) begin
            // A full FIFO drops the word and forces NACK regardless of the earlier decision.
            push       = space;
            push_last  = !(ack_q && space);
            ack_d      = ack_q && space;
            sda_oe_d   = (ack_q && space) ? SdaDrive : SdaRelease;
            if (!space) overflow_d = 1'b1;
            state_d    = StAckHold;
          end
        end
        StAckHold: begin
          if (scl_fall) begin
            sda_oe_d   = SdaRelease;
            word_cnt_d = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;
            state_d    = ack_q ? StShift : StWaitStop;
          end
        end
        StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      ack_q      <= 1'b0;
      sda_oe_q   <= SdaRelease;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
      rx_en_q    <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      overflow_q <= overflow_d;
      rx_en_q    <= rx_en_i;
    end
  end

  i2c_rx_fifo #(
    .Width (DATA_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  ({push_last, shreg_q}),
    .space_o (space),
    .ready_i (rx_ready_i),
    .valid_o (rx_valid_o),
    .data_o  (fifo_rdata)
  );

  assign rx_data_o  = fifo_rdata[DATA_W-1:0];
  assign rx_last_o  = fifo_rdata[DATA_W];
  assign sda_oe_o   = sda_oe_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != StIdle);

endmodule
